fifo_rd_sequencer: RTL and testbench
====================================

// Module: fifo_rd_sequencer
// PURPOSE
//  Avalon-MM slave that sequences reads from the ultrasonic sample FIFO for the NIOS.
//  It replaces manual toggling of a PIO read strobe with a programmed transfer.
//  - The CPU writes a word count and a start bit.
//  - The block issues one FIFO read per word, honouring fifo_empty and the FIFO's read latency.
//  - It presents each word in a one-deep holding register that the CPU pops by reading DATA.
//  Sits between the NIOS data master and the FIFO read port; raises irq when the transfer completes.
// PARAMETERS
//  DATA_W       16  FIFO word width (1..32); zero-extended onto readdata
//  CNT_W        16  width of COUNT / remaining counter (1..16)
//  RD_LATENCY   1   cycles from fifo_rdreq to valid fifo_q (1..4)
//  TIMEOUT_CYC  0   max cycles waiting on fifo_empty before abort; 0 = no timeout
// PORTS
//  clk         in   1       clock
//  reset_n     in   1       asynchronous, active-low reset
//  address     in   2       register select: 0 CTRL, 1 COUNT, 2 DATA, 3 STATUS
//  chipselect  in   1       slave select
//  write_n     in   1       active-low write strobe
//  read_n      in   1       active-low read strobe (DATA pop side-effect)
//  writedata   in   32      write data
//  readdata    out  32      combinational read mux, zero wait states
//  irq         out  1       done & irq_en
//  fifo_rdreq  out  1       FIFO read request, one-cycle pulse per word
//  fifo_q      in   DATA_W  FIFO read data
//  fifo_empty  in   1       FIFO empty flag
// BEHAVIOUR
//  Reset: state IDLE; fifo_rdreq=0; irq=0; COUNT=0; remaining=0; data_hold=0.
//    Reset also clears valid, done, timeout and irq_en. Reset is honoured mid-transfer.
//  CTRL write: bit0 start, bit1 abort, bit2 irq_en (level, stored).
//    CTRL read: {29'b0, irq_en, 1'b0, busy}.
//  COUNT: read/write, low CNT_W bits. A write while busy is ignored.
//  DATA read: returns {0, data_hold}. When valid=1 the read pops: valid<=0 next edge.
//    A read with valid=0 returns the stale data_hold and has no effect.
//  STATUS read: {remaining[15:0], 12'b0, timeout, valid, done, busy}.
//    STATUS write: bit1=1 clears done, bit3=1 clears timeout (W1C).
//    When set and clear coincide in the same cycle, set wins.
//  busy = (state != IDLE).
//  FSM:
//   IDLE: start & COUNT>0 -> WAIT_FIFO; remaining<=COUNT; done<=0; wait counter cleared.
//     start & COUNT==0 -> done<=1, stay IDLE.
//     start while busy -> ignored.
//   WAIT_FIFO: fifo_empty=0 -> fifo_rdreq<=1 for exactly one cycle; -> LATENCY.
//     Otherwise increment wait counter.
//     TIMEOUT_CYC!=0 & counter==TIMEOUT_CYC-1 -> timeout<=1, done<=1, -> IDLE.
//   LATENCY: rdreq high in cycle T; fifo_q sampled on the edge ending cycle T+RD_LATENCY-1+1.
//     On that edge: data_hold<=fifo_q; valid<=1; remaining<=remaining-1; -> HOLD.
//   HOLD: wait for DATA pop.
//     On pop: remaining==0 -> done<=1, -> IDLE; else -> WAIT_FIFO with wait counter cleared.
//  Abort (CTRL bit1), any state: -> IDLE next edge; fifo_rdreq<=0; valid<=0; remaining<=0.
//    done is not set. A word in flight in LATENCY is dropped; the FIFO has already consumed it.
//    Abort takes priority over start in the same write.
//  Throughput: at most one outstanding FIFO read; rdreq never issued while valid=1 or fifo_empty=1.
//  remaining never wraps below 0; COUNT is unchanged by transfers, so start re-runs the same length.
// TESTING
//  1 Reset: readdata of all regs = 0, fifo_rdreq=0, irq=0.
//  2 Basic: COUNT=3, start, FIFO preloaded A,B,C, RD_LATENCY=1.
//    -> 3 single rdreq pulses; DATA reads return A,B,C.
//    -> STATUS done=1 after third pop; irq=1 when irq_en=1.
//  3 Empty stall: COUNT=2, FIFO empty 20 cycles then 2 words.
//    -> no rdreq while empty; transfer completes; timeout=0.
//  4 Timeout: TIMEOUT_CYC=8, COUNT=1, FIFO held empty.
//    -> 8 cycles after start: timeout=1, done=1, busy=0.
//    -> W1C of 0xA clears both flags.
//  5 Abort: COUNT=4; abort in LATENCY after 1st rdreq.
//    -> busy=0, valid=0, remaining=0, done=0.
//    -> a new start re-runs with remaining=4.
//  6 Edge cases:
//    - start with COUNT=0 -> done=1 immediately, no rdreq.
//    - DATA read with valid=0 -> no state change.
//    - COUNT write while busy -> ignored.
//    - RD_LATENCY=3 -> capture lands 3 cycles after rdreq.

Source files
------------

// File: rtl/fifo_rd_sequencer_if.sv
// Bus bundle between the NIOS Avalon-MM data master, the FIFO read port and the read sequencer.
// The sequencer uses the slave view; the CPU/FIFO side uses the master view.
interface fifo_rd_sequencer_if #(
   parameter int DATA_W = 16
);
   logic [1:0]        address;
   logic              chipselect;
   logic              write_n;
   logic              read_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              irq;
   logic              fifo_rdreq;
   logic [DATA_W-1:0] fifo_q;
   logic              fifo_empty;

   modport slave (
      input  address, chipselect, write_n, read_n, writedata, fifo_q, fifo_empty,
      output readdata, irq, fifo_rdreq
   );

   modport master (
      output address, chipselect, write_n, read_n, writedata, fifo_q, fifo_empty,
      input  readdata, irq, fifo_rdreq
   );
endinterface

// File: rtl/fifo_rd_sequencer.sv
// Avalon-MM slave that runs a programmed burst of FIFO reads and hands each word to the CPU
// through a one-deep holding register popped by reading DATA.
module fifo_rd_sequencer #(
   parameter int DATA_W      = 16,
   parameter int CNT_W       = 16,
   parameter int RD_LATENCY  = 1,
   parameter int TIMEOUT_CYC = 0
) (
   input logic                  clk,
   input logic                  reset_n,
   fifo_rd_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, WAIT_FIFO, LATENCY, HOLD} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  remaining_q;
   logic [DATA_W-1:0] dataHold_q;
   logic              valid_q;
   logic              done_q;
   logic              timeout_q;
   logic              irqEn_q;
   logic              rdreq_q;
   logic [31:0]       waitCnt_q;
   logic [2:0]        latCnt_q;

   logic        wrEn, rdEn, ctrlWr, countWr, statusWr;
   logic        start, abort, pop, busy;
   logic        unusedWd;

   assign wrEn     = bus.chipselect & ~bus.write_n;
   assign rdEn     = bus.chipselect & ~bus.read_n;
   assign ctrlWr   = wrEn & (bus.address == 2'd0);
   assign countWr  = wrEn & (bus.address == 2'd1);
   assign statusWr = wrEn & (bus.address == 2'd3);
   assign start    = ctrlWr & bus.writedata[0];
   assign abort    = ctrlWr & bus.writedata[1];
   assign pop      = rdEn & (bus.address == 2'd2) & valid_q;
   assign busy     = (state_q != IDLE);
   assign unusedWd = ^bus.writedata;

   assign bus.fifo_rdreq = rdreq_q;
   assign bus.irq        = done_q & irqEn_q;

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         2'd0:    bus.readdata = {29'b0, irqEn_q, 1'b0, busy};
         2'd1:    bus.readdata = 32'(count_q);
         2'd2:    bus.readdata = 32'(dataHold_q);
         default: bus.readdata = {16'(remaining_q), 12'b0, timeout_q, valid_q, done_q, busy};
      endcase
   end

   // W1C clears are applied before the FSM so that a same-cycle set from the FSM wins.
   // Abort overrides everything else, including a capture landing on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         remaining_q <= '0;
         dataHold_q  <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         irqEn_q     <= 1'b0;
         rdreq_q     <= 1'b0;
         waitCnt_q   <= '0;
         latCnt_q    <= '0;
      end else begin
         rdreq_q <= 1'b0;
         if (countWr && !busy) count_q <= bus.writedata[CNT_W-1:0];
         if (ctrlWr) irqEn_q <= bus.writedata[2];
         if (statusWr && bus.writedata[1]) done_q <= 1'b0;
         if (statusWr && bus.writedata[3]) timeout_q <= 1'b0;
         if (pop) valid_q <= 1'b0;

         if (abort) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            remaining_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     if (count_q != '0) begin
                        state_q     <= WAIT_FIFO;
                        remaining_q <= count_q;
                        done_q      <= 1'b0;
                        waitCnt_q   <= '0;
                     end else begin
                        done_q <= 1'b1;
                     end
                  end
               end
               WAIT_FIFO: begin
                  if (!bus.fifo_empty) begin
                     rdreq_q  <= 1'b1;
                     latCnt_q <= '0;
                     state_q  <= LATENCY;
                  end else if (TIMEOUT_CYC != 0 && waitCnt_q == 32'(TIMEOUT_CYC - 1)) begin
                     timeout_q <= 1'b1;
                     done_q    <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     waitCnt_q <= waitCnt_q + 32'd1;
                  end
               end
               LATENCY: begin
                  if (latCnt_q == 3'(RD_LATENCY)) begin
                     dataHold_q <= bus.fifo_q;
                     valid_q    <= 1'b1;
                     if (remaining_q != '0) remaining_q <= remaining_q - 1'b1;
                     state_q    <= HOLD;
                  end else begin
                     latCnt_q <= latCnt_q + 3'd1;
                  end
               end
               default: begin
                  if (pop) begin
                     if (remaining_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                     end else begin
                        waitCnt_q <= '0;
                        state_q   <= WAIT_FIFO;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_sequencer.sv
// Bench for fifo_rd_sequencer: two instances (latency 1 / no timeout, latency 3 / timeout 8)
// driven over their Avalon ports and fed by a behavioural FIFO with configurable read latency.
module tb_fifo_rd_sequencer;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   fifo_rd_sequencer_if #(.DATA_W(16)) ifA ();
   fifo_rd_sequencer_if #(.DATA_W(16)) ifB ();

   fifo_rd_sequencer #(.DATA_W(16), .CNT_W(16), .RD_LATENCY(1), .TIMEOUT_CYC(0)) dutA (
      .clk(clk), .reset_n(reset_n), .bus(ifA.slave));
   fifo_rd_sequencer #(.DATA_W(16), .CNT_W(16), .RD_LATENCY(3), .TIMEOUT_CYC(8)) dutB (
      .clk(clk), .reset_n(reset_n), .bus(ifB.slave));

   always #5 clk = ~clk;

   logic [15:0] fifoMem [2][64];
   logic [5:0]  wrPtr [2] = '{default: '0};
   logic [5:0]  rdPtr [2] = '{default: '0};
   logic [15:0] sr [2][4] = '{default: '0};
   logic        holdEmpty [2] = '{default: 1'b0};
   logic        prevRdreq [2] = '{default: 1'b0};
   int          rdCnt [2] = '{default: 0};
   int          badCnt [2] = '{default: 0};
   int          lastRdEdge [2] = '{default: 0};
   int          cyc = 0;
   logic [1:0]  rdreqV;

   assign rdreqV = {ifB.fifo_rdreq, ifA.fifo_rdreq};
   assign ifA.fifo_q = sr[0][0];
   assign ifB.fifo_q = sr[1][2];
   assign ifA.fifo_empty = holdEmpty[0] || (wrPtr[0] == rdPtr[0]);
   assign ifB.fifo_empty = holdEmpty[1] || (wrPtr[1] == rdPtr[1]);

   // Behavioural FIFO: a sampled rdreq pops one word, which then ripples through a delay line
   // so that it shows on fifo_q RD_LATENCY cycles after the request cycle.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int u = 0; u < 2; u++) begin
         prevRdreq[u] <= rdreqV[u];
         for (int k = 1; k < 4; k++) sr[u][k] <= sr[u][k-1];
         if (rdreqV[u]) begin
            if (wrPtr[u] == rdPtr[u] || prevRdreq[u]) badCnt[u] <= badCnt[u] + 1;
            sr[u][0]      <= fifoMem[u][rdPtr[u]];
            rdPtr[u]      <= rdPtr[u] + 6'd1;
            rdCnt[u]      <= rdCnt[u] + 1;
            lastRdEdge[u] <= cyc + 1;
         end else begin
            sr[u][0] <= '0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] statusWord(input int rem, input logic to, input logic v,
                                              input logic d, input logic b);
      logic [31:0] r;
      r = 32'(rem);
      return {r[15:0], 12'b0, to, v, d, b};
   endfunction

   task automatic driveBus(input int u, input logic [1:0] addr, input logic cs, input logic wn,
                           input logic rn, input logic [31:0] wd);
      if (u == 0) begin
         ifA.address = addr; ifA.chipselect = cs; ifA.write_n = wn; ifA.read_n = rn; ifA.writedata = wd;
      end else begin
         ifB.address = addr; ifB.chipselect = cs; ifB.write_n = wn; ifB.read_n = rn; ifB.writedata = wd;
      end
   endtask

   task automatic applyStimulus(input int u, input logic [1:0] addr, input logic [31:0] wd);
      driveBus(u, addr, 1'b1, 1'b0, 1'b1, wd);
      @(posedge clk);
      @(negedge clk);
      driveBus(u, 2'd0, 1'b0, 1'b1, 1'b1, 32'd0);
   endtask

   task automatic busRead(input int u, input logic [1:0] addr, output logic [31:0] rd);
      driveBus(u, addr, 1'b1, 1'b1, 1'b0, 32'd0);
      #1;
      rd = (u == 0) ? ifA.readdata : ifB.readdata;
      @(posedge clk);
      @(negedge clk);
      driveBus(u, 2'd0, 1'b0, 1'b1, 1'b1, 32'd0);
   endtask

   task automatic pushWord(input int u, input logic [15:0] w);
      fifoMem[u][wrPtr[u]] = w;
      wrPtr[u] = wrPtr[u] + 6'd1;
   endtask

   task automatic waitValid(input int u, input string tag, output int seenCyc);
      logic [31:0] st;
      bit found = 0;
      seenCyc = -1;
      for (int n = 0; n < 50 && !found; n++) begin
         int c = cyc;
         busRead(u, 2'd3, st);
         if (st[2]) begin
            found = 1;
            seenCyc = c;
         end
      end
      if (!found) checkOutput({tag, "_valid_wait"}, 32'd0, 32'd1);
   endtask

   task automatic popWord(input int u, input logic [15:0] w, input string tag);
      logic [31:0] rd;
      int seen;
      waitValid(u, tag, seen);
      busRead(u, 2'd2, rd);
      checkOutput(tag, rd, {16'b0, w});
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic [15:0] w [8];
      int r0, seen, first, n, stall;
      logic ie;

      driveBus(0, 2'd0, 1'b0, 1'b1, 1'b1, 32'd0);
      driveBus(1, 2'd0, 1'b0, 1'b1, 1'b1, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int a = 0; a < 4; a++) begin
         busRead(0, 2'(a), rd);
         checkOutput($sformatf("reset_reg%0d", a), rd, 32'd0);
      end
      checkOutput("reset_rdreq", 32'(rdreqV), 32'd0);
      checkOutput("reset_irq", 32'(ifA.irq), 32'd0);

      // Basic three-word transfer with interrupts enabled.
      for (int k = 0; k < 3; k++) begin w[k] = 16'($urandom); pushWord(0, w[k]); end
      applyStimulus(0, 2'd1, 32'd3);
      applyStimulus(0, 2'd0, 32'h4);
      busRead(0, 2'd0, rd);
      checkOutput("ctrl_irq_en", rd, 32'h4);
      r0 = rdCnt[0];
      applyStimulus(0, 2'd0, 32'h5);
      for (int k = 0; k < 3; k++) begin
         waitValid(0, "basic", seen);
         if (k == 0) checkOutput("basic_latency", 32'(seen - lastRdEdge[0]), 32'd1);
         busRead(0, 2'd3, rd);
         checkOutput($sformatf("basic_status%0d", k), rd, statusWord(2 - k, 1'b0, 1'b1, 1'b0, 1'b1));
         busRead(0, 2'd2, rd);
         checkOutput($sformatf("basic_data%0d", k), rd, {16'b0, w[k]});
      end
      busRead(0, 2'd3, rd);
      checkOutput("basic_done", rd, statusWord(0, 1'b0, 1'b0, 1'b1, 1'b0));
      checkOutput("basic_irq", 32'(ifA.irq), 32'd1);
      checkOutput("basic_rdreqs", 32'(rdCnt[0] - r0), 32'd3);
      applyStimulus(0, 2'd3, 32'h2);
      checkOutput("basic_irq_clr", 32'(ifA.irq), 32'd0);

      // Stall on an empty FIFO for 20 cycles with no timeout configured.
      holdEmpty[0] = 1'b1;
      for (int k = 0; k < 2; k++) begin w[k] = 16'($urandom); pushWord(0, w[k]); end
      applyStimulus(0, 2'd1, 32'd2);
      r0 = rdCnt[0];
      applyStimulus(0, 2'd0, 32'h1);
      repeat (20) @(negedge clk);
      checkOutput("stall_no_rdreq", 32'(rdCnt[0] - r0), 32'd0);
      busRead(0, 2'd3, rd);
      checkOutput("stall_status", rd, statusWord(2, 1'b0, 1'b0, 1'b0, 1'b1));
      holdEmpty[0] = 1'b0;
      for (int k = 0; k < 2; k++) popWord(0, w[k], $sformatf("stall_data%0d", k));
      busRead(0, 2'd3, rd);
      checkOutput("stall_done", rd, statusWord(0, 1'b0, 1'b0, 1'b1, 1'b0));
      applyStimulus(0, 2'd3, 32'h2);

      // Timeout after 8 empty cycles, then W1C of both flags.
      holdEmpty[1] = 1'b1;
      applyStimulus(1, 2'd1, 32'd1);
      applyStimulus(1, 2'd0, 32'h1);
      first = -1;
      for (int i = 0; i < 12; i++) begin
         busRead(1, 2'd3, rd);
         if (rd[3] && first < 0) first = i;
      end
      checkOutput("timeout_cycle", 32'(first), 32'd8);
      checkOutput("timeout_status", rd, statusWord(1, 1'b1, 1'b0, 1'b1, 1'b0));
      applyStimulus(1, 2'd3, 32'hA);
      busRead(1, 2'd3, rd);
      checkOutput("timeout_w1c", rd, statusWord(1, 1'b0, 1'b0, 1'b0, 1'b0));
      holdEmpty[1] = 1'b0;

      // Abort while the first word is in flight; that word is lost, the re-run gets the next four.
      for (int k = 0; k < 5; k++) begin w[k] = 16'($urandom); pushWord(0, w[k]); end
      applyStimulus(0, 2'd1, 32'd4);
      r0 = rdCnt[0];
      applyStimulus(0, 2'd0, 32'h1);
      for (int i = 0; i < 20 && rdCnt[0] == r0; i++) @(negedge clk);
      checkOutput("abort_saw_rdreq", 32'(rdCnt[0] - r0), 32'd1);
      applyStimulus(0, 2'd0, 32'h2);
      busRead(0, 2'd3, rd);
      checkOutput("abort_status", rd, 32'd0);
      repeat (4) @(negedge clk);
      checkOutput("abort_no_more_rdreq", 32'(rdCnt[0] - r0), 32'd1);
      applyStimulus(0, 2'd0, 32'h1);
      busRead(0, 2'd3, rd);
      checkOutput("abort_rerun_remaining", rd, statusWord(4, 1'b0, 1'b0, 1'b0, 1'b1));
      for (int k = 1; k < 5; k++) popWord(0, w[k], $sformatf("abort_data%0d", k));
      busRead(0, 2'd3, rd);
      checkOutput("abort_rerun_done", rd, statusWord(0, 1'b0, 1'b0, 1'b1, 1'b0));
      applyStimulus(0, 2'd3, 32'h2);

      // Start with COUNT=0 completes at once without touching the FIFO.
      applyStimulus(0, 2'd1, 32'd0);
      r0 = rdCnt[0];
      applyStimulus(0, 2'd0, 32'h1);
      busRead(0, 2'd3, rd);
      checkOutput("zero_count_done", rd, statusWord(0, 1'b0, 1'b0, 1'b1, 1'b0));
      checkOutput("zero_count_rdreq", 32'(rdCnt[0] - r0), 32'd0);
      applyStimulus(0, 2'd3, 32'h2);

      // DATA read with nothing held returns the stale word and changes nothing.
      busRead(0, 2'd2, rd);
      checkOutput("stale_data", rd, {16'b0, w[4]});
      busRead(0, 2'd3, rd);
      checkOutput("stale_status", rd, 32'd0);

      // COUNT write while busy is ignored.
      holdEmpty[0] = 1'b1;
      for (int k = 0; k < 2; k++) begin w[k] = 16'($urandom); pushWord(0, w[k]); end
      applyStimulus(0, 2'd1, 32'd2);
      applyStimulus(0, 2'd0, 32'h1);
      applyStimulus(0, 2'd1, 32'd7);
      busRead(0, 2'd1, rd);
      checkOutput("count_busy_ignored", rd, 32'd2);
      holdEmpty[0] = 1'b0;
      for (int k = 0; k < 2; k++) popWord(0, w[k], $sformatf("count_busy_data%0d", k));
      applyStimulus(0, 2'd3, 32'h2);

      // Read latency of 3 on the second instance.
      w[0] = 16'($urandom);
      pushWord(1, w[0]);
      applyStimulus(1, 2'd0, 32'h1);
      waitValid(1, "lat3", seen);
      checkOutput("lat3_capture", 32'(seen - lastRdEdge[1]), 32'd3);
      busRead(1, 2'd2, rd);
      checkOutput("lat3_data", rd, {16'b0, w[0]});
      busRead(1, 2'd3, rd);
      checkOutput("lat3_done", rd, statusWord(0, 1'b0, 1'b0, 1'b1, 1'b0));
      applyStimulus(1, 2'd3, 32'h2);

      // Randomized transfers on both instances.
      for (int it = 0; it < 10; it++) begin
         int u = it % 2;
         n = $urandom_range(1, 4);
         ie = 1'($urandom_range(0, 1));
         holdEmpty[u] = 1'b1;
         for (int k = 0; k < n; k++) begin w[k] = 16'($urandom); pushWord(u, w[k]); end
         applyStimulus(u, 2'd1, 32'(n));
         r0 = rdCnt[u];
         applyStimulus(u, 2'd0, {29'b0, ie, 2'b01});
         stall = (u == 1) ? $urandom_range(0, 4) : $urandom_range(0, 12);
         repeat (stall) @(negedge clk);
         holdEmpty[u] = 1'b0;
         for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            popWord(u, w[k], $sformatf("rand%0d_data%0d", it, k));
         end
         busRead(u, 2'd3, rd);
         checkOutput($sformatf("rand%0d_done", it), rd, statusWord(0, 1'b0, 1'b0, 1'b1, 1'b0));
         checkOutput($sformatf("rand%0d_irq", it), 32'((u == 0) ? ifA.irq : ifB.irq), 32'(ie));
         checkOutput($sformatf("rand%0d_rdreqs", it), 32'(rdCnt[u] - r0), 32'(n));
         applyStimulus(u, 2'd3, 32'h2);
      end

      checkOutput("rdreq_protocol_A", 32'(badCnt[0]), 32'd0);
      checkOutput("rdreq_protocol_B", 32'(badCnt[1]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
